// File: rtl/serial_alu_dw.sv
// Digit-serial ALU: DW bits per cycle for add/sub/logic/compare, one bit per
// cycle for shifts, with a start/ready/done handshake toward the core FSM.
module serial_alu_dw #(
  parameter int XLEN = 32,
  parameter int DW   = 1
) (
  input  logic            w_clk,
  input  logic            w_rst_x,
  input  logic            w_start,
  input  logic [3:0]      w_op,
  input  logic [XLEN-1:0] w_a,
  input  logic [XLEN-1:0] w_b,
  output logic            w_ready,
  output logic            r_done,
  output logic [XLEN-1:0] r_result,
  output logic            r_flag
);

  localparam int N  = XLEN / DW;
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_NE   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SHIFT, S_DONE} state_t;

  function automatic logic uses_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU) ||
           (op == OP_EQ) || (op == OP_NE);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [3:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d, neq_q, neq_d;
  logic            done_q, done_d, flag_q, flag_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [DW-1:0]   a_dig_s, b_dig_s, b_add_s, res_dig_s;
  logic [DW:0]     sum_s;
  logic [XLEN-1:0] dig_ext_s, run_acc_s, shift_acc_s;
  logic            ovf_s, slt_s, sltu_s, eq_s;

  assign w_ready  = (state_q == S_IDLE);
  assign r_done   = done_q;
  assign r_result = result_q;
  assign r_flag   = flag_q;

  // Digit datapath; SUB and compares run as A + ~B + 1 with carry seeded at issue.
  always_comb begin
    a_dig_s   = a_q[DW-1:0];
    b_dig_s   = b_q[DW-1:0];
    b_add_s   = uses_sub(op_q) ? ~b_dig_s : b_dig_s;
    sum_s     = {1'b0, a_dig_s} + {1'b0, b_add_s} + {{DW{1'b0}}, carry_q};
    res_dig_s = '0;
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_EQ, OP_NE: res_dig_s = sum_s[DW-1:0];
      OP_XOR:  res_dig_s = a_dig_s ^ b_dig_s;
      OP_OR:   res_dig_s = a_dig_s | b_dig_s;
      OP_AND:  res_dig_s = a_dig_s & b_dig_s;
      default: res_dig_s = '0;
    endcase
    dig_ext_s          = '0;
    dig_ext_s[DW-1:0]  = res_dig_s;
    run_acc_s          = (acc_q >> DW) | (dig_ext_s << (XLEN - DW));
    // Only meaningful on the last digit, which carries both operand sign bits.
    ovf_s  = (a_dig_s[DW-1] ^ b_dig_s[DW-1]) & (sum_s[DW-1] ^ a_dig_s[DW-1]);
    slt_s  = sum_s[DW-1] ^ ovf_s;
    sltu_s = ~sum_s[DW];
    eq_s   = ~(neq_q | (|(a_dig_s ^ b_dig_s)));
    case (op_q)
      OP_SLL:  shift_acc_s = acc_q << 1;
      OP_SRL:  shift_acc_s = acc_q >> 1;
      OP_SRA:  shift_acc_s = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: shift_acc_s = acc_q;
    endcase
  end

  // Next-state and datapath register updates for the control FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    neq_d    = neq_q;
    done_d   = 1'b0;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          a_d     = w_a;
          b_d     = w_b;
          op_d    = w_op;
          carry_d = uses_sub(w_op);
          neq_d   = 1'b0;
          if (is_shift(w_op)) begin
            acc_d = w_a;
            cnt_d = {1'b0, w_b[SW-1:0]};
            if (w_b[SW-1:0] == '0) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = w_a;
              flag_d   = 1'b0;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            acc_d   = '0;
            cnt_d   = CNT_N;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DW;
        b_d     = b_q >> DW;
        acc_d   = run_acc_s;
        carry_d = sum_s[DW];
        neq_d   = neq_q | (|(a_dig_s ^ b_dig_s));
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          case (op_q)
            OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: begin
              result_d = run_acc_s;
              flag_d   = 1'b0;
            end
            OP_SLT: begin
              result_d = {{(XLEN-1){1'b0}}, slt_s};
              flag_d   = slt_s;
            end
            OP_SLTU: begin
              result_d = {{(XLEN-1){1'b0}}, sltu_s};
              flag_d   = sltu_s;
            end
            OP_EQ: begin
              result_d = {{(XLEN-1){1'b0}}, eq_s};
              flag_d   = eq_s;
            end
            OP_NE: begin
              result_d = {{(XLEN-1){1'b0}}, ~eq_s};
              flag_d   = ~eq_s;
            end
            default: begin
              result_d = '0;
              flag_d   = 1'b0;
            end
          endcase
        end else begin
          state_d = S_RUN;
        end
      end
      S_SHIFT: begin
        acc_d = shift_acc_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = shift_acc_s;
          flag_d   = 1'b0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge w_clk or negedge w_rst_x) begin
    if (!w_rst_x) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= 4'd0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      neq_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      neq_q    <= neq_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_dw.sv
// Directed bench for serial_alu_dw: one DW=1 and one DW=4 instance, XLEN=32.
module tb_serial_alu_dw;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        s1, s4;
  logic [3:0]  op1, op4;
  logic [31:0] a1, b1, a4, b4;
  logic        rdy1, rdy4, d1, d4, f1, f4;
  logic [31:0] r1, r4;
  int          errors = 0;
  int          checks = 0;
  int          n;
  int          pulses;

  always #5 clk = ~clk;

  serial_alu_dw #(.XLEN(32), .DW(1)) dut1 (
    .w_clk(clk), .w_rst_x(rst_x), .w_start(s1), .w_op(op1), .w_a(a1), .w_b(b1),
    .w_ready(rdy1), .r_done(d1), .r_result(r1), .r_flag(f1)
  );

  serial_alu_dw #(.XLEN(32), .DW(4)) dut4 (
    .w_clk(clk), .w_rst_x(rst_x), .w_start(s4), .w_op(op4), .w_a(a4), .w_b(b4),
    .w_ready(rdy4), .r_done(d4), .r_result(r4), .r_flag(f4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the chosen instance, measure latency in cycles, check outputs.
  task automatic run(input bit wide, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] er,
                     input logic ef, input string tag);
    int   cyc;
    logic dn;
    @(negedge clk);
    if (wide) begin
      s4 = 1'b1; op4 = op; a4 = a; b4 = b;
    end else begin
      s1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
    @(negedge clk);
    if (wide) begin
      s4 = 1'b0; op4 = 4'd3; a4 = ~a; b4 = ~b;
      chk({tag, ".busy"}, {31'd0, rdy4}, 32'd0);
      dn = d4;
    end else begin
      s1 = 1'b0; op1 = 4'd3; a1 = ~a; b1 = ~b;
      chk({tag, ".busy"}, {31'd0, rdy1}, 32'd0);
      dn = d1;
    end
    cyc = 1;
    while (!dn && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dn = wide ? d4 : d1;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(lat));
    chk({tag, ".res"}, wide ? r4 : r1, er);
    chk({tag, ".flag"}, {31'd0, wide ? f4 : f1}, {31'd0, ef});
  endtask

  initial begin
    rst_x = 1'b0;
    s1 = 1'b0; op1 = 4'd0; a1 = 32'd0; b1 = 32'd0;
    s4 = 1'b0; op4 = 4'd0; a4 = 32'd0; b4 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, rdy4}, 32'd1);
    chk("rst.done", {31'd0, d4}, 32'd0);
    chk("rst.res", r4, 32'd0);
    chk("rst.flag", {31'd0, f4}, 32'd0);
    chk("rst.ready1", {31'd0, rdy1}, 32'd1);
    rst_x = 1'b1;

    run(1'b0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32'h0000_0000, 1'b0, "dw1.add");
    run(1'b0, 4'd1, 32'h0000_0005, 32'h0000_0007, 33, 32'hFFFF_FFFE, 1'b0, "dw1.sub");
    run(1'b0, 4'd8, 32'h8000_0000, 32'h0000_0001, 33, 32'h0000_0001, 1'b1, "dw1.slt");

    run(1'b1, 4'd1, 32'h0000_0000, 32'h0000_0001, 9, 32'hFFFF_FFFF, 1'b0, "sub");
    run(1'b1, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 9, 32'h0FF0_0FF0, 1'b0, "xor");
    run(1'b1, 4'd0, 32'h1234_5678, 32'h0FED_CBA8, 9, 32'h2222_2220, 1'b0, "add");
    run(1'b1, 4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 9, 32'hFFFF_F0F0, 1'b0, "or");
    run(1'b1, 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 9, 32'hF000_F000, 1'b0, "and");
    run(1'b1, 4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 9, 32'h0000_0001, 1'b1, "slt");
    run(1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 9, 32'h0000_0000, 1'b0, "sltu");
    run(1'b1, 4'd8, 32'h7FFF_FFFF, 32'h8000_0000, 9, 32'h0000_0000, 1'b0, "slt.ovf");
    run(1'b1, 4'd9, 32'h7FFF_FFFF, 32'h8000_0000, 9, 32'h0000_0001, 1'b1, "sltu.2");
    run(1'b1, 4'd7, 32'h8000_0000, 32'h0000_0004, 5, 32'hF800_0000, 1'b0, "sra");
    run(1'b1, 4'd5, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 1'b0, "sll0");
    run(1'b1, 4'd6, 32'h8000_0000, 32'h0000_001F, 32, 32'h0000_0001, 1'b0, "srl31");
    run(1'b1, 4'd5, 32'h0000_000F, 32'h0000_0004, 5, 32'h0000_00F0, 1'b0, "sll4");
    run(1'b1, 4'd10, 32'h1234_5678, 32'h1234_5678, 9, 32'h0000_0001, 1'b1, "eq");
    run(1'b1, 4'd11, 32'h1234_5678, 32'h1234_5678, 9, 32'h0000_0000, 1'b0, "ne");
    run(1'b1, 4'd10, 32'h9234_5678, 32'h1234_5678, 9, 32'h0000_0000, 1'b0, "eq.b31");
    run(1'b1, 4'd11, 32'h9234_5678, 32'h1234_5678, 9, 32'h0000_0001, 1'b1, "ne.b31");

    // A second start while busy must not disturb the first op or queue a second one.
    @(negedge clk);
    s4 = 1'b1; op4 = 4'd0; a4 = 32'd5; b4 = 32'd3;
    @(negedge clk);
    s4 = 1'b0; n = 1;
    @(negedge clk);
    n = 2; s4 = 1'b1; op4 = 4'd2; a4 = 32'd1; b4 = 32'd1;
    @(negedge clk);
    n = 3; s4 = 1'b0;
    while (!d4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy.lat", 32'(n), 32'd9);
    chk("busy.res", r4, 32'd8);
    @(negedge clk);
    chk("busy.ready", {31'd0, rdy4}, 32'd1);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (d4) pulses++;
    end
    chk("busy.nodone", 32'(pulses), 32'd0);

    run(1'b1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'h0000_0000, 1'b0, "illegal13");
    run(1'b1, 4'd0, 32'h0000_0100, 32'h0000_0023, 9, 32'h0000_0123, 1'b0, "add.pre");

    // Asynchronous reset in the middle of RUN, away from any clock edge.
    @(negedge clk);
    s4 = 1'b1; op4 = 4'd0; a4 = 32'd1; b4 = 32'd1;
    @(negedge clk);
    s4 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_x = 1'b0;
    #1;
    chk("arst.res", r4, 32'd0);
    chk("arst.done", {31'd0, d4}, 32'd0);
    chk("arst.ready", {31'd0, rdy4}, 32'd1);
    chk("arst.flag", {31'd0, f4}, 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (d4) pulses++;
    end
    chk("arst.nodone", 32'(pulses), 32'd0);
    chk("arst.res2", r4, 32'd0);

    run(1'b1, 4'd1, 32'h0000_0010, 32'h0000_0001, 9, 32'h0000_000F, 1'b0, "post.sub");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
